// File: rtl/busy_counter_reader.sv
// busy_counter_reader
//
// Readout side for the gam/grad busy-cycle counters. A read request snapshots
// both counters on the same clock edge. The snapshot is then streamed out as
// WORD_W-bit words over a valid/ready interface, least-significant word first:
// gam words first, then grad words. The live counters keep running, and the
// two halves of the readout stay mutually consistent.
//
// Optional feature, enabled by defining BUSY_COUNTER_READER_CHECKSUM_EN:
// one extra word follows the payload. It is the XOR of all payload words, and
// it carries out_last.
//
// Ports:
//   clock              in   system clock, posedge
//   reset              in   asynchronous active-high reset
//   read_req           in   request a snapshot + readout
//   gam_busy_counter   in   live gam count   [CNT_W]
//   grad_busy_counter  in   live grad count  [CNT_W]
//   out_data           out  stream word      [WORD_W]
//   out_valid          out  out_data valid
//   out_ready          in   consumer accepts word when high with out_valid
//   out_last           out  final word of a readout
//   busy               out  readout in progress
//   req_overrun        out  one-cycle pulse: read_req seen while busy (dropped)
module busy_counter_reader #(
  parameter int unsigned CNT_W  = 128,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read_req,
  input  logic [CNT_W-1:0]  gam_busy_counter,
  input  logic [CNT_W-1:0]  grad_busy_counter,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              req_overrun
);

  localparam int unsigned NWORDS = 2 * CNT_W / WORD_W;
  localparam int unsigned SNAP_W = 2 * CNT_W;
`ifdef BUSY_COUNTER_READER_CHECKSUM_EN
  localparam int unsigned NTOTAL = NWORDS + 1;
`else
  localparam int unsigned NTOTAL = NWORDS;
`endif
  localparam int unsigned IDX_W = $clog2(NWORDS + 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NTOTAL - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                overrun_q, overrun_d;
  logic [SNAP_W-1:0]   live;
  logic [IDX_W-1:0]    nxt_idx;
  logic [WORD_W-1:0]   nxt_word;

  // Word k of the flat snapshot {grad, gam}; k = 0 is gam[WORD_W-1:0].
  function automatic logic [WORD_W-1:0] word_of(input logic [SNAP_W-1:0] v,
                                                 input logic [IDX_W-1:0]  i);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
      if (i == IDX_W'(k)) w = v[k*WORD_W +: WORD_W];
    end
    return w;
  endfunction

  assign live = {grad_busy_counter, gam_busy_counter};

`ifdef BUSY_COUNTER_READER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;

  function automatic logic [WORD_W-1:0] xor_words(input logic [SNAP_W-1:0] v);
    logic [WORD_W-1:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < NWORDS; k++) acc ^= v[k*WORD_W +: WORD_W];
    return acc;
  endfunction
`endif

  assign nxt_idx = idx_q + 1'b1;

  always_comb begin
    nxt_word = word_of(snap_q, nxt_idx);
`ifdef BUSY_COUNTER_READER_CHECKSUM_EN
    if (nxt_idx == IDX_W'(NWORDS)) nxt_word = csum_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    overrun_d = 1'b0;
`ifdef BUSY_COUNTER_READER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (read_req) begin
          // Both counters are captured on the same edge.
          snap_d  = live;
          idx_d   = '0;
          data_d  = live[WORD_W-1:0];
          valid_d = 1'b1;
          last_d  = 1'b0;
          state_d = StSend;
`ifdef BUSY_COUNTER_READER_CHECKSUM_EN
          csum_d  = xor_words(live);
`endif
        end
      end
      StSend: begin
        // A request arriving during a readout, including on the final-transfer
        // edge, is dropped and reported.
        overrun_d = read_req;
        if (out_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d  = nxt_idx;
            data_d = nxt_word;
            last_d = (nxt_idx == LastIdx);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef BUSY_COUNTER_READER_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign busy        = (state_q == StSend);
  assign req_overrun = overrun_q;

endmodule

// File: tb/tb_busy_counter_reader.sv
// Directed testbench for busy_counter_reader: reset, basic readout,
// backpressure, snapshot isolation, overrun, mid-readout reset, all-ones.
module tb_busy_counter_reader;

`ifdef BUSY_COUNTER_READER_CHECKSUM_EN
  localparam int NT = 9;
`else
  localparam int NT = 8;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         read_req;
  logic [127:0] gam;
  logic [127:0] grad;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         req_overrun;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_w [0:8];

  always #5 clock = ~clock;

  busy_counter_reader #(
    .CNT_W (128),
    .WORD_W(32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .read_req         (read_req),
    .gam_busy_counter (gam),
    .grad_busy_counter(grad),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .busy             (busy),
    .req_overrun      (req_overrun)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Checksum word = XOR of the eight hand-written payload words.
  task automatic set_csum;
    exp_w[8] = 32'h0;
    for (int k = 0; k < 8; k++) exp_w[8] ^= exp_w[k];
  endtask

  task automatic test_reset;
    reset = 1'b1; read_req = 1'b0; out_ready = 1'b0; gam = '0; grad = '0;
    #12;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || req_overrun !== 1'b0
        || out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset: valid=%b busy=%b last=%b ovr=%b data=%h, want all 0",
               out_valid, busy, out_last, req_overrun, out_data);
    end
    tick;
    reset = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b valid=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic;
    gam  = 128'h0000000A_00000000_00000000_00000005;
    grad = 128'h1;
    exp_w[0] = 32'h5; exp_w[1] = 32'h0; exp_w[2] = 32'h0; exp_w[3] = 32'hA;
    exp_w[4] = 32'h1; exp_w[5] = 32'h0; exp_w[6] = 32'h0; exp_w[7] = 32'h0;
    set_csum;
    out_ready = 1'b1; read_req = 1'b1;
    tick;
    read_req = 1'b0;
    for (int i = 0; i < NT; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_w[i] || out_last !== (i == NT - 1)
          || busy !== 1'b1) begin
        bad++;
        $display("FAIL basic word %0d: valid=%b data=%h last=%b busy=%b, want 1 %h %b 1",
                 i, out_valid, out_data, out_last, busy, exp_w[i], (i == NT - 1));
      end
      tick;
    end
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL basic end: busy=%b valid=%b last=%b, want 0 0 0", busy, out_valid, out_last);
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    int n;
    int cyc;
    pat = 4'b1001;  // ready per cycle: 1,0,0,1 repeating
    n = 0; cyc = 0;
    read_req = 1'b1;
    tick;
    read_req = 1'b0;
    while (n < NT && cyc < 60) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_w[n] || out_last !== (n == NT - 1)) begin
        bad++;
        $display("FAIL backpressure cyc %0d: valid=%b data=%h last=%b, want 1 %h %b",
                 cyc, out_valid, out_data, out_last, exp_w[n], (n == NT - 1));
      end
      out_ready = pat[cyc % 4];
      tick;
      if (out_ready) n++;
      cyc++;
    end
    total++;
    if (n != NT || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure end: words=%0d busy=%b valid=%b, want %0d 0 0",
               n, busy, out_valid, NT);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_snapshot;
    gam  = 128'd100;
    grad = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    exp_w[0] = 32'h64;       exp_w[1] = 32'h0;        exp_w[2] = 32'h0;
    exp_w[3] = 32'h0;        exp_w[4] = 32'hCAFEF00D; exp_w[5] = 32'h89ABCDEF;
    exp_w[6] = 32'h01234567; exp_w[7] = 32'hDEADBEEF;
    set_csum;
    read_req = 1'b1;
    tick;
    read_req = 1'b0;
    for (int i = 0; i < NT; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
        bad++;
        $display("FAIL snapshot word %0d: valid=%b data=%h, want 1 %h",
                 i, out_valid, out_data, exp_w[i]);
      end
      gam  = gam + 128'd1;
      grad = grad + 128'd3;
      tick;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL snapshot end: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_overrun;
    int ov;
    ov = 0;
    gam  = 128'h0000000A_00000000_00000000_00000005;
    grad = 128'h1;
    exp_w[0] = 32'h5; exp_w[1] = 32'h0; exp_w[2] = 32'h0; exp_w[3] = 32'hA;
    exp_w[4] = 32'h1; exp_w[5] = 32'h0; exp_w[6] = 32'h0; exp_w[7] = 32'h0;
    set_csum;
    read_req = 1'b1;
    tick;
    read_req = 1'b0;
    for (int i = 0; i < NT; i++) begin
      total++;
      if (out_data !== exp_w[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL overrun word %0d: valid=%b data=%h, want 1 %h",
                 i, out_valid, out_data, exp_w[i]);
      end
      if (req_overrun) ov++;
      gam = gam + 128'h100;  // dropped request must not resnapshot
      read_req = (i == 2 || i == NT - 1);
      tick;
      if (i == 2) read_req = 1'b0;
    end
    // Final-transfer edge: request dropped, still held high for the next edge.
    if (req_overrun) ov++;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || req_overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun final edge: busy=%b valid=%b ovr=%b, want 0 0 1",
               busy, out_valid, req_overrun);
    end
    gam = 128'h0000000A_00000000_00000000_00000005;
    tick;
    read_req = 1'b0;
    total++;
    if (busy !== 1'b1 || out_data !== 32'h5 || req_overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun restart: busy=%b data=%h ovr=%b, want 1 00000005 0",
               busy, out_data, req_overrun);
    end
    for (int i = 0; i < NT; i++) begin
      if (req_overrun) ov++;
      total++;
      if (out_data !== exp_w[i]) begin
        bad++;
        $display("FAIL overrun second word %0d: data=%h, want %h", i, out_data, exp_w[i]);
      end
      tick;
    end
    total++;
    if (ov != 2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL overrun count: pulses=%0d busy=%b, want 2 0", ov, busy);
    end
  endtask

  task automatic test_reset_mid;
    read_req = 1'b1; out_ready = 1'b1;
    tick;
    read_req = 1'b0;
    tick; tick; tick;
    out_ready = 1'b0;
    total++;
    if (out_data !== exp_w[3]) begin
      bad++;
      $display("FAIL reset_mid pre: data=%h, want %h", out_data, exp_w[3]);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid async: valid=%b busy=%b last=%b data=%h, want 0 0 0 0",
               out_valid, busy, out_last, out_data);
    end
    #2 reset = 1'b0;
    gam  = 128'h00000004_00000003_00000002_00000001;
    grad = 128'h00000008_00000007_00000006_00000005;
    for (int k = 0; k < 8; k++) exp_w[k] = k + 1;
    set_csum;
    read_req = 1'b1; out_ready = 1'b1;
    tick;
    read_req = 1'b0;
    for (int i = 0; i < NT; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_w[i] || out_last !== (i == NT - 1)) begin
        bad++;
        $display("FAIL reset_mid word %0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, out_valid, out_data, out_last, exp_w[i], (i == NT - 1));
      end
      tick;
    end
  endtask

  task automatic test_all_ones;
    gam  = '1;
    grad = '1;
    for (int k = 0; k < 8; k++) exp_w[k] = 32'hFFFFFFFF;
    exp_w[8] = 32'h00000000;
    read_req = 1'b1;
    tick;
    read_req = 1'b0;
    for (int i = 0; i < NT; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_w[i] || out_last !== (i == NT - 1)) begin
        bad++;
        $display("FAIL all_ones word %0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, out_valid, out_data, out_last, exp_w[i], (i == NT - 1));
      end
      tick;
    end
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL all_ones end: busy=%b valid=%b, want 0 0", busy, out_valid);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_snapshot;
    test_overrun;
    test_reset_mid;
    test_all_ones;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/busy_counter_reader.md
Name: busy_counter_reader

Overview:
- Readout side for the gam/grad busy-cycle counters.
- On a read request, atomically snapshots both 128-bit counters in the same cycle and streams them out as 32-bit words over a valid/ready interface.
- The host-facing logic or a UART/AXI bridge drains the stream.
- Snapshot isolation keeps the two counters mutually consistent while they keep counting.

Parameters:
- CNT_W, 128, width of each busy counter input; must be a multiple of WORD_W.
- WORD_W, 32, output word width.
- NWORDS (localparam), 2*CNT_W/WORD_W = 8, payload words per readout.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- read_req  input  1  request a snapshot and readout; sampled every cycle.
- gam_busy_counter  input  CNT_W  live gam busy-cycle count.
- grad_busy_counter  input  CNT_W  live grad busy-cycle count.
- out_data  output  WORD_W  current stream word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word when asserted together with out_valid.
- out_last  output  1  marks the final word of a readout.
- busy  output  1  a readout is in progress (snapshot held).
- req_overrun  output  1  one-cycle pulse when read_req arrives while busy.

Behaviour:
- Reset (async, active-high): state=IDLE; out_data=0, out_valid=0, out_last=0, busy=0, req_overrun=0; snapshot regs=0; word index=0.
- State machine, IDLE -> SEND:
  - Transition when read_req=1 at a posedge.
  - At that same edge both inputs are captured into snap_gam/snap_grad, index=0, busy=1, out_valid=1, out_data=word0.
  - Latency is one edge from request to first valid word.
- Word order, least-significant word first:
  - Words 0..3 = snap_gam[31:0], [63:32], [95:64], [127:96].
  - Words 4..7 = snap_grad in the same order.
- SEND, handshake:
  - A word transfers on a posedge with out_valid&&out_ready.
  - On transfer of a non-final word: index+1 and out_data advances at that edge.
  - When out_ready=0: out_data, out_last and out_valid hold stable, with no dependency on out_ready within the cycle.
- SEND, final word:
  - out_last=1 exactly while the final word is presented.
  - On its transfer: state=IDLE, out_valid=0, out_last=0, busy=0.
- No back-to-back readout:
  - read_req on the edge where the final word transfers is treated as an overrun and is not accepted.
  - The earliest new request is accepted the following cycle.
- Overrun:
  - read_req=1 while state=SEND (busy=1) pulses req_overrun for one cycle.
  - The request is dropped and the snapshot is unchanged.
- Inputs changing during SEND have no effect on the stream; only the snapshot is sent.
- Index counter width is $clog2(NWORDS+1), compared against the terminal value. No wrap beyond the final word.
- Reset asserted mid-readout aborts immediately to the reset values; no partial-completion obligation.
- Counter values are sent verbatim, with no saturation or arithmetic; the all-ones value 2^128-1 is sent as four 0xFFFFFFFF words.

Optional Feature:
- Macro: BUSY_COUNTER_READER_CHECKSUM_EN.
- Defined:
  - A ninth word is appended after word 7: the XOR of all 8 payload words.
  - out_last moves to the checksum word; total of 9 transfers.
  - Checksum accumulates at snapshot time, not from live inputs.
- Undefined:
  - Exactly 8 words; out_last on word 7; no checksum logic synthesized.

Test Plan:
1. Reset, then gam=0x0000000A_00000000_00000000_00000005, grad=128'h1; pulse read_req with out_ready=1.
   - Required: words 0x5, 0, 0, 0xA, 0x1, 0, 0, 0 on 8 consecutive cycles.
   - out_last only on word 7; busy falls after the final transfer.
2. Backpressure: same stimulus with out_ready toggling 1,0,0,1,...
   - Required: no word skipped or duplicated; out_data is stable across every ready=0 cycle.
3. Snapshot isolation: increment gam_busy_counter every cycle during SEND from a starting value of 100.
   - Required: all words reflect the value 100 captured at the read_req edge.
4. Overrun: read_req asserted on words 2 and 7 (final-transfer edge).
   - Required: req_overrun pulses twice; exactly one 8-word readout completes.
   - A read_req one cycle after the final transfer starts a new readout.
5. Reset mid-readout: assert reset after 3 transfers.
   - Required: out_valid/busy/out_last are 0 asynchronously.
   - After release, a new read_req sends from word 0.
6. With BUSY_COUNTER_READER_CHECKSUM_EN, gam=grad=all ones.
   - Required: 8 words of 0xFFFFFFFF, then a checksum of 0x00000000 with out_last=1.
